// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator input path.
//   BTN_C..BTN_D : bit positions of the five buttons in btn_raw/btn_level/btn_pulse
//   deb_state_t  : per-button debounce FSM states
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button: 2-flop synchronizer, debounce FSM with saturating counter, and
// (when BTN_AUTOREPEAT_EN is defined) an auto-repeat strobe generator.
// Ports:
//   clc   in  : system clock, rising edge
//   rst   in  : synchronous active-high reset
//   raw   in  : asynchronous bouncy button input
//   level out : registered debounced level
//   pulse out : registered one-cycle strobe per accepted press (plus repeats)
// Optional feature macro: BTN_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clc,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_r;
    logic          synced_s;
    deb_state_t    state_r, state_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          level_nxt;
    logic          press_pulse_s;
    logic          rep_pulse_s;

    assign synced_s = sync_r[1];

    // Synchronizer, FSM state, counter and registered outputs.
    always_ff @(posedge clc) begin
        if (rst) begin
            sync_r  <= 2'b00;
            state_r <= IDLE;
            cnt_r   <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], raw};
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            level   <= level_nxt;
            pulse   <= press_pulse_s | rep_pulse_s;
        end
    end

    // Next-state logic: the counter value written on entering a wait state is
    // already compared against the terminal count, so DEBOUNCE_CYCLES=1
    // accepts on the very first synced sample.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        press_pulse_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (synced_s) begin
                    if (CNT_ONE == CNT_TERM) begin
                        state_nxt     = PRESSED;
                        cnt_nxt       = '0;
                        press_pulse_s = 1'b1;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (synced_s) begin
                    if ((cnt_r + CNT_ONE) == CNT_TERM) begin
                        state_nxt     = PRESSED;
                        cnt_nxt       = '0;
                        press_pulse_s = 1'b1;
                    end else begin
                        cnt_nxt = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                if (!synced_s) begin
                    if (CNT_ONE == CNT_TERM) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!synced_s) begin
                    if ((cnt_r + CNT_ONE) == CNT_TERM) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt_r, rep_cnt_nxt, rep_inc_s, rep_lim_s;
    logic          rep_first_r, rep_first_nxt;

    // Repeat counter and first-repeat flag.
    always_ff @(posedge clc) begin
        if (rst) begin
            rep_cnt_r   <= '0;
            rep_first_r <= 1'b1;
        end else begin
            rep_cnt_r   <= rep_cnt_nxt;
            rep_first_r <= rep_first_nxt;
        end
    end

    // Counts cycles spent continuously in PRESSED; first limit is the delay,
    // later limits the period. Any exit or fresh entry restarts the sequence.
    always_comb begin
        rep_inc_s     = rep_cnt_r + RW'(1);
        rep_lim_s     = rep_first_r ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
        rep_cnt_nxt   = '0;
        rep_first_nxt = 1'b1;
        rep_pulse_s   = 1'b0;
        if ((state_r == PRESSED) && (state_nxt == PRESSED)) begin
            if (rep_inc_s == rep_lim_s) begin
                rep_pulse_s   = 1'b1;
                rep_cnt_nxt   = '0;
                rep_first_nxt = 1'b0;
            end else begin
                rep_cnt_nxt   = rep_inc_s;
                rep_first_nxt = rep_first_r;
            end
        end else begin
            rep_cnt_nxt   = '0;
            rep_first_nxt = 1'b1;
        end
    end
`else
    assign rep_pulse_s = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Synchronizes and debounces the board push-buttons and synchronizes the
// slide switches for the calculator datapath.
// Ports:
//   clc       in  : system clock, rising edge
//   rst       in  : synchronous active-high reset
//   btn_raw   in  : [N_BTN] raw buttons, bit order c,l,u,r,d (bit 0 = c)
//   sw_raw    in  : [16] raw slide switches
//   btn_level out : [N_BTN] debounced levels
//   btn_pulse out : [N_BTN] one-cycle press strobes
//   sw_sync   out : [16] switches after a 2-flop synchronizer
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat press strobes)
// -----------------------------------------------------------------------------
module btn_conditioner
    import calc_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clc,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [15:0]      sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic [15:0]      sw_sync
);

    logic [15:0] sw_meta_r;

    // Switch synchronizer bank; no debounce on switches.
    always_ff @(posedge clc) begin
        if (rst) begin
            sw_meta_r <= 16'h0000;
            sw_sync   <= 16'h0000;
        end else begin
            sw_meta_r <= sw_raw;
            sw_sync   <= sw_meta_r;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_deb (
            .clc   (clc),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed scenarios followed by randomized stimulus, checked every cycle
// against a run-length reference model of the debounce rules.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clc = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  btn_raw = '0;
    logic [15:0]   sw_raw = 16'h0000;
    logic [N-1:0]  btn_level;
    logic [N-1:0]  btn_pulse;
    logic [15:0]   sw_sync;

    btn_conditioner #(
        .N_BTN           (N),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clc       (clc),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .sw_raw    (sw_raw),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse),
        .sw_sync   (sw_sync)
    );

    always #5 clc = ~clc;

    // Reference model state: raw samples from the last two edges, accepted
    // level, length of the current run of samples disagreeing with it, and
    // how long the button has been continuously accepted-and-stable.
    logic [N-1:0] h1, h2;
    logic [15:0]  sw_h1, sw_h2;
    logic [N-1:0] m_level, m_pulse;
    int           run  [N];
    int           held [N];
    int           tally[N];
    int           vectors = 0;
    int           miscompares = 0;

    task automatic tick();
        logic [N-1:0] s;
        logic         stable_before;
        @(posedge clc);
        m_pulse = '0;
        if (rst) begin
            h1 = '0; h2 = '0; sw_h1 = 16'h0000; sw_h2 = 16'h0000;
            m_level = '0;
            for (int i = 0; i < N; i++) begin
                run[i] = 0;
                held[i] = 0;
            end
        end else begin
            s = h2;
            h2 = h1;
            h1 = btn_raw;
            sw_h2 = sw_h1;
            sw_h1 = sw_raw;
            for (int i = 0; i < N; i++) begin
                stable_before = m_level[i] && (run[i] == 0);
                if (s[i] != m_level[i]) run[i] = run[i] + 1;
                else run[i] = 0;
                if (run[i] == D) begin
                    m_level[i] = ~m_level[i];
                    run[i] = 0;
                    if (m_level[i]) m_pulse[i] = 1'b1;
                end
`ifdef BTN_AUTOREPEAT_EN
                if (m_level[i] && (run[i] == 0) && stable_before && !m_pulse[i]) begin
                    held[i] = held[i] + 1;
                    if ((held[i] == RD) || ((held[i] > RD) && (((held[i] - RD) % RP) == 0)))
                        m_pulse[i] = 1'b1;
                end else begin
                    held[i] = 0;
                end
`else
                held[i] = stable_before ? 0 : 0;
`endif
            end
        end
        #1;
        vectors++;
        for (int i = 0; i < N; i++) tally[i] = tally[i] + (btn_pulse[i] ? 1 : 0);
        assert (btn_level === m_level) else begin
            miscompares++;
            $error("FAIL level: got %b expected %b at %0t", btn_level, m_level, $time);
        end
        assert (btn_pulse === m_pulse) else begin
            miscompares++;
            $error("FAIL pulse: got %b expected %b at %0t", btn_pulse, m_pulse, $time);
        end
        assert (sw_sync === sw_h2) else begin
            miscompares++;
            $error("FAIL sw_sync: got %h expected %h at %0t", sw_sync, sw_h2, $time);
        end
    endtask

    task automatic clear_tally();
        for (int i = 0; i < N; i++) tally[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            run[i] = 0; held[i] = 0; tally[i] = 0;
        end
        h1 = '0; h2 = '0; sw_h1 = 16'h0000; sw_h2 = 16'h0000;
        m_level = '0; m_pulse = '0;

        // 1: reset with all buttons held, then accepted as fresh presses
        rst = 1'b1; btn_raw = 5'b11111;
        repeat (3) tick();
        assert (btn_level === 5'b00000 && btn_pulse === 5'b00000) else begin
            miscompares++;
            $error("FAIL reset_outputs: got level %b pulse %b expected 00000", btn_level, btn_pulse);
        end
        vectors++;
        rst = 1'b0;
        clear_tally();
        repeat (10) tick();
        assert (tally[0] + tally[1] + tally[2] + tally[3] + tally[4] === 5) else begin
            miscompares++;
            $error("FAIL reset_fresh_press: got %0d pulses expected 5", tally[0] + tally[1] + tally[2] + tally[3] + tally[4]);
        end
        vectors++;
        btn_raw = 5'b00000;
        repeat (8) tick();

        // 2: clean press and release of d
        clear_tally();
        btn_raw[4] = 1'b1;
        repeat (20) tick();
        btn_raw[4] = 1'b0;
        repeat (8) tick();
`ifndef BTN_AUTOREPEAT_EN
        assert (tally[4] === 1) else begin
            miscompares++;
            $error("FAIL d_single_pulse: got %0d pulses expected 1", tally[4]);
        end
        vectors++;
`endif

        // 3: bounce on l is rejected
        clear_tally();
        btn_raw[1] = 1'b1; tick();
        btn_raw[1] = 1'b0; tick();
        btn_raw[1] = 1'b1; tick();
        btn_raw[1] = 1'b1; tick();
        btn_raw[1] = 1'b0;
        repeat (10) tick();
        assert (tally[1] === 0) else begin
            miscompares++;
            $error("FAIL bounce_reject: got %0d pulses expected 0", tally[1]);
        end
        vectors++;

        // 4: simultaneous c and r
        btn_raw = 5'b01001;
        repeat (8) tick();
        btn_raw = 5'b00000;
        repeat (8) tick();

        // 5: reset mid-debounce on u, plus switch latency
        btn_raw[2] = 1'b1;
        repeat (3) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        sw_raw = 16'hA5C3;
        repeat (8) tick();
        assert (sw_sync === 16'hA5C3) else begin
            miscompares++;
            $error("FAIL sw_pattern: got %h expected a5c3", sw_sync);
        end
        vectors++;
        btn_raw = 5'b00000;
        repeat (8) tick();

`ifdef BTN_AUTOREPEAT_EN
        // 6: held d with auto-repeat
        clear_tally();
        btn_raw[4] = 1'b1;
        repeat (30) tick();
        btn_raw[4] = 1'b0;
        repeat (10) tick();
`endif

        // Randomized phase: sparse toggles give a mix of bounces and holds
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) btn_raw[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) sw_raw = 16'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        btn_raw = 5'b00000;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input-conditioning stage placed directly upstream of the calculator datapath. It synchronizes and debounces the five raw push-buttons and the 16 slide switches from the board. For each button it produces a clean debounced level and a single-cycle press strobe. The top level drives `btnd` from the down-button press strobe, so one physical press loads the accumulator exactly once. `btnu`, `btnl`, `btnc` and `btnr` are driven from the debounced levels.

## Interface
- `N_BTN`, 5: number of buttons; bit order is c, l, u, r, d (bit 0 = c).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change; must be ≥ 1.
- `REPEAT_DELAY`, 25000000: cycles a press is held before the first auto-repeat strobe. Used only with the macro.
- `REPEAT_PERIOD`, 5000000: cycles between subsequent auto-repeat strobes. Used only with the macro.
- `clc` input 1: system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_raw` input N_BTN: asynchronous, bouncy button inputs.
- `sw_raw` input 16: asynchronous slide switches.
- `btn_level` output N_BTN: debounced button state.
- `btn_pulse` output N_BTN: one-cycle strobe per accepted press.
- `sw_sync` output 16: 2-flop synchronized switches (no debounce).

## Operation
- Every `btn_raw` and `sw_raw` bit passes through a 2-flop synchronizer. Both flops reset to 0.
- Each button has an independent FSM with one counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - IDLE: level 0. Synced input = 1 → PRESS_WAIT, counter := 1.
  - PRESS_WAIT: synced 1 → counter++. When counter reaches DEBOUNCE_CYCLES: → PRESSED, level := 1, pulse := 1 for that cycle. Synced 0 at any point → IDLE, counter := 0.
  - PRESSED: level 1. Synced 0 → RELEASE_WAIT, counter := 1.
  - RELEASE_WAIT: synced 0 → counter++. When counter reaches DEBOUNCE_CYCLES: → IDLE, level := 0. Synced 1 → PRESSED, counter := 0.
- A release never generates a pulse.
- Glitches shorter than DEBOUNCE_CYCLES are fully rejected, and the counter restarts from the next change.
- Buttons are independent. Simultaneous presses each yield their own pulse in their own acceptance cycle, and pulses may coincide.
- The counter saturates and never wraps, because the FSM leaves the wait state on the terminal count.
- Reset mid-debounce aborts the count: FSM → IDLE, counter 0.
- A button held high through reset release is treated as a fresh press. It is accepted after full latency and emits one pulse.

## Timing
- Reset values: `btn_level`=0, `btn_pulse`=0, `sw_sync`=0, all FSMs IDLE, all counters 0.
- Switch latency: `sw_sync` follows `sw_raw` 2 cycles later.
- Button press latency: raw first sampled 1 at edge k and held → `btn_level` and `btn_pulse` both rise at edge k+1+DEBOUNCE_CYCLES.
  - 2 cycles are synchronizer.
  - The counter hits terminal on the same edge it is loaded/incremented.
- `btn_pulse` is high for exactly 1 cycle per accepted press, regardless of hold time (without macro).
- Release latency equals press latency. There is no pulse on release.
- Outputs are registered. There are no combinational paths from inputs.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - While a button stays in PRESSED, a repeat counter runs.
  - The first extra `btn_pulse` comes REPEAT_DELAY cycles after the acceptance pulse.
  - Further pulses follow every REPEAT_PERIOD cycles until release begins (leaving PRESSED).
  - The repeat counter clears on leaving PRESSED and on reset.
- Undefined: no repeat logic is instantiated. There is exactly one pulse per press, and the REPEAT_* parameters are ignored.

## Structure
- Shared package `calc_pkg`:
  - Button index constants `BTN_C`=0, `BTN_L`=1, `BTN_U`=2, `BTN_R`=3, `BTN_D`=4.
  - Debounce state enum {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
- Sub-module `btn_debounce`: one button's synchronizer, FSM, counter and optional repeat logic. It is instantiated N_BTN times via generate.
- The switch synchronizer is a plain 16-bit 2-flop register bank in the top of the block.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4. Scenario 6 also uses REPEAT_DELAY=10, REPEAT_PERIOD=3.

1. Reset: assert `rst` with `btn_raw`=5'b11111 → all outputs 0 while reset is held. After release, `btn_level`=5'b11111 and a single `btn_pulse`=5'b11111 at the 5th edge.
2. Clean press of d: `btn_raw[4]` 0→1 held 20 cycles → `btn_pulse[4]` high exactly 1 cycle at the 5th edge after the first sampled-high edge, and `btn_level[4]` stays 1. The release gives `btn_level[4]`=0 five edges later with no pulse.
3. Bounce rejection: `btn_raw[1]` toggles 1,0,1,1,0 every cycle, then stays 0 → `btn_level[1]` and `btn_pulse[1]` remain 0 throughout.
4. Simultaneous: `btn_raw[0]` and `btn_raw[3]` rise on the same edge → both pulses in the same cycle; other bits stay 0.
5. Reset mid-debounce: `btn_raw[2]`=1 for 3 cycles, `rst` pulsed for 1 cycle, raw held → no pulse before, pulse 5 edges after reset deasserts. Switches: `sw_raw`=16'hA5C3 → `sw_sync`=16'hA5C3 two cycles later.
6. With `BTN_AUTOREPEAT_EN`: hold `btn_raw[4]` for 30 cycles → pulses at acceptance, then +10, +13, +16, +19… until release starts; none after.
